// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for blocks that drive an external SR latch.
// Holds the arbiter FSM encoding, the op encoding and a small sizing helper.
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic OP_SET   = 1'b1;
    localparam logic OP_RESET = 1'b0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sr_latch_cmd_arbiter_rr_pick.sv
// Combinational round-robin first-set finder: searches req from ptr+1 upward
// with wrap-around and reports the first set index.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          any
);

    logic [IW-1:0] idx;

    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        // The current pointer is visited last, so it has the lowest priority.
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(ptr) + i) % N);
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/sr_latch_cmd_arbiter.sv
// Round-robin arbiter sharing one external SR latch among N requesters:
// pulses S or R, waits for the latch to settle, samples Q and acks with status.
module sr_latch_cmd_arbiter
    import sr_ctrl_pkg::*;
#(
    parameter int N              = 2,
    parameter int PULSE_CYCLES   = 2,
    parameter int SETTLE_CYCLES  = 1,
    parameter int SKIP_REDUNDANT = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic [N-1:0] op,
    input  logic         q_in,
    output logic         s_out,
    output logic         r_out,
    output logic [N-1:0] ack,
    output logic         err,
    output logic         busy,
    output logic         known,
    output logic         mirror
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(max_int(PULSE_CYCLES, SETTLE_CYCLES) + 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [IW-1:0] g_q, g_n;
    logic          op_q, op_n;
    logic          skip_q, skip_n;

    logic [IW-1:0] g_pick;
    logic          any;

    logic          s_d, r_d, err_d, known_d, mirror_d;
    logic [N-1:0]  ack_d;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (g_pick),
        .any   (any)
    );

    // State, counter and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            ptr    <= IW'(N - 1);
            g_q    <= '0;
            op_q   <= OP_RESET;
            skip_q <= 1'b0;
            s_out  <= 1'b0;
            r_out  <= 1'b0;
            ack    <= '0;
            err    <= 1'b0;
            known  <= 1'b0;
            mirror <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            ptr    <= ptr_n;
            g_q    <= g_n;
            op_q   <= op_n;
            skip_q <= skip_n;
            s_out  <= s_d;
            r_out  <= r_d;
            ack    <= ack_d;
            err    <= err_d;
            known  <= known_d;
            mirror <= mirror_d;
        end
    end

    // Next-state logic. DONE is the last zero-drive cycle and the Q sample
    // point, so SETTLE lasts SETTLE_CYCLES-1 cycles and the ack lands one
    // cycle after DONE.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        g_n     = g_q;
        op_n    = op_q;
        skip_n  = skip_q;
        case (state)
            IDLE: begin
                // A req still high during the ack cycle is the old command.
                if (any && (ack == '0)) begin
                    g_n    = g_pick;
                    ptr_n  = g_pick;
                    op_n   = op[g_pick];
                    skip_n = 1'b0;
                    if ((SKIP_REDUNDANT != 0) && known && (op[g_pick] == mirror)) begin
                        skip_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        state_n = DRIVE;
                        cnt_n   = CW'(PULSE_CYCLES - 1);
                    end
                end
            end
            DRIVE: begin
                if (cnt == '0) begin
                    if (SETTLE_CYCLES > 1) begin
                        state_n = SETTLE;
                        cnt_n   = CW'(SETTLE_CYCLES - 2);
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            SETTLE: begin
                if (cnt == '0) state_n = DONE;
                else           cnt_n   = cnt - CW'(1);
            end
            DONE: begin
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        s_d      = (state_n == DRIVE) &&  op_n;
        r_d      = (state_n == DRIVE) && !op_n;
        ack_d    = '0;
        err_d    = 1'b0;
        known_d  = known;
        mirror_d = mirror;
        if (state == DONE) begin
            ack_d[g_q] = 1'b1;
            if (!skip_q) begin
                // An X or Z on q_in is treated as a mismatch.
                err_d = (q_in !== op_q);
                if (err_d) begin
                    known_d = 1'b0;
                end else begin
                    known_d  = 1'b1;
                    mirror_d = op_q;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
